fetch_predict_unit: RTL and testbench

//  Instruction-fetch stage of the 5-stage MIPS pipeline; producer side of the IF/ID register.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/btb_table.sv | 69 ++++++
 rtl/fetch_predict_unit.sv | 101 ++++++++++
 tb/tb_fetch_predict_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch stage and its branch target buffer.
package fetch_pkg;

    // 2-bit saturating branch counter; the MSB is the taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        ctr_t n;
        n = c;
        case (c)
            SNT:     n = taken ? WNT : SNT;
            WNT:     n = taken ? WT  : SNT;
            WT:      n = taken ? ST  : WNT;
            ST:      n = taken ? ST  : WT;
            default: n = c;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped branch target buffer: combinational lookup port, synchronous
// train port, synchronous clear on reset. Addresses arrive as word addresses.
module btb_table
    import fetch_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:2] i_rd_pc,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    input  logic        i_upd_en,
    input  logic [31:2] i_upd_pc,
    input  logic        i_upd_taken,
    input  logic [31:0] i_upd_target
);
    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    logic             r_valid  [BTB_ENTRIES];
    ctr_t             r_ctr    [BTB_ENTRIES];
    logic [TAG_W-1:0] r_tag    [BTB_ENTRIES];
    logic [31:0]      r_target [BTB_ENTRIES];

    logic [IDX_W-1:0] w_rd_idx;
    logic [TAG_W-1:0] w_rd_tag;
    logic             w_rd_hit;
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;

    assign w_rd_idx = i_rd_pc[IDX_W+1:2];
    assign w_rd_tag = i_rd_pc[31:IDX_W+2];
    assign w_rd_hit = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);

    assign o_pred_taken  = w_rd_hit && r_ctr[w_rd_idx][1];
    assign o_pred_target = r_valid[w_rd_idx] ? r_target[w_rd_idx] : '0;

    assign w_up_idx = i_upd_pc[IDX_W+1:2];
    assign w_up_tag = i_upd_pc[31:IDX_W+2];
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    // Lookup reads the registered arrays, so a same-cycle train of the same
    // index is only seen by the following cycle's lookup.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                r_valid[i[IDX_W-1:0]]  <= 1'b0;
                r_ctr[i[IDX_W-1:0]]    <= SNT;
                r_tag[i[IDX_W-1:0]]    <= '0;
                r_target[i[IDX_W-1:0]] <= '0;
            end
        end else if (i_upd_en) begin
            if (w_up_hit) begin
                r_ctr[w_up_idx] <= ctr_next(r_ctr[w_up_idx], i_upd_taken);
                if (i_upd_taken) begin
                    r_target[w_up_idx] <= i_upd_target;
                end
            end else begin
                r_valid[w_up_idx]  <= 1'b1;
                r_tag[w_up_idx]    <= w_up_tag;
                r_ctr[w_up_idx]    <= i_upd_taken ? WT : WNT;
                r_target[w_up_idx] <= i_upd_target;
            end
        end
    end

endmodule

// File: rtl/fetch_predict_unit.sv
// MIPS instruction-fetch stage: PC register, BTB-driven next-PC selection.
// Define FETCH_PERF_CNT_EN to add fetch/predict/mispredict counters.
module fetch_predict_unit
    import fetch_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = 64,
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        RedirectE,
    input  logic [31:0] RedirectPCE,
    input  logic        UpdateEn,
    input  logic [31:0] UpdatePC,
    input  logic        UpdateTaken,
    input  logic [31:0] UpdateTarget,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        JumpPredictF,
    output logic [31:0] PredTargetF
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] PerfFetchCnt,
    output logic [31:0] PerfPredCnt,
    output logic [31:0] PerfMispredCnt
`endif
);
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic        w_unused_upd_lsbs;

    assign PCF      = r_pc;
    assign PCPlus4F = r_pc + 32'd4;

    // Byte-offset bits never take part in BTB indexing or tagging.
    assign w_unused_upd_lsbs = ^UpdatePC[1:0];

    btb_table #(
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_rd_pc       (r_pc[31:2]),
        .o_pred_taken  (JumpPredictF),
        .o_pred_target (PredTargetF),
        .i_upd_en      (UpdateEn),
        .i_upd_pc      (UpdatePC[31:2]),
        .i_upd_taken   (UpdateTaken),
        .i_upd_target  (UpdateTarget)
    );

    always_comb begin
        w_pc_next = PCPlus4F;
        if (RedirectE) begin
            w_pc_next = RedirectPCE;
        end else if (StallF) begin
            w_pc_next = r_pc;
        end else if (JumpPredictF) begin
            w_pc_next = PredTargetF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_pred_cnt;
    logic [31:0] r_mispred_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_cnt   <= '0;
            r_pred_cnt    <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (!StallF) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            // Counts predictions that actually steer the PC.
            if (JumpPredictF && !StallF && !RedirectE) begin
                r_pred_cnt <= r_pred_cnt + 32'd1;
            end
            if (RedirectE) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign PerfFetchCnt   = r_fetch_cnt;
    assign PerfPredCnt    = r_pred_cnt;
    assign PerfMispredCnt = r_mispred_cnt;
`endif

endmodule

// File: tb/tb_fetch_predict_unit.sv
// Self-checking bench for fetch_predict_unit: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural BTB model.
module tb_fetch_predict_unit;
    localparam int unsigned N   = 64;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        StallF;
    logic        RedirectE;
    logic [31:0] RedirectPCE;
    logic        UpdateEn;
    logic [31:0] UpdatePC;
    logic        UpdateTaken;
    logic [31:0] UpdateTarget;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        JumpPredictF;
    logic [31:0] PredTargetF;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_predict_unit #(
        .BTB_ENTRIES (N),
        .RESET_PC    (RPC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .StallF       (StallF),
        .RedirectE    (RedirectE),
        .RedirectPCE  (RedirectPCE),
        .UpdateEn     (UpdateEn),
        .UpdatePC     (UpdatePC),
        .UpdateTaken  (UpdateTaken),
        .UpdateTarget (UpdateTarget),
        .PCF          (PCF),
        .PCPlus4F     (PCPlus4F),
        .JumpPredictF (JumpPredictF),
        .PredTargetF  (PredTargetF)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model: the table is a plain array indexed by word address
    // modulo the entry count; counters are integers clamped to 0..3.
    bit          m_init = 1'b0;
    logic [31:0] m_pc;
    bit          m_valid [N];
    int unsigned m_tag   [N];
    int          m_ctr   [N];
    logic [31:0] m_tgt   [N];

    function automatic int unsigned midx(input logic [31:0] pc);
        return (pc / 32'd4) % N;
    endfunction

    function automatic int unsigned mtag(input logic [31:0] pc);
        return pc / (32'd4 * N);
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_valid[midx(pc)] && (m_tag[midx(pc)] == mtag(pc)) && (m_ctr[midx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
        return m_valid[midx(pc)] ? m_tgt[midx(pc)] : 32'd0;
    endfunction

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                m_valid[k] = 1'b0;
                m_tag[k]   = 0;
                m_ctr[k]   = 0;
                m_tgt[k]   = 32'd0;
            end
            m_pc   = RPC;
            m_init = 1'b1;
        end else if (m_init) begin
            logic [31:0] nxt;
            int unsigned ui;
            if (RedirectE)           nxt = RedirectPCE;
            else if (StallF)         nxt = m_pc;
            else if (m_pred(m_pc))   nxt = m_ptgt(m_pc);
            else                     nxt = m_pc + 32'd4;
            if (UpdateEn) begin
                ui = midx(UpdatePC);
                if (m_valid[ui] && m_tag[ui] == mtag(UpdatePC)) begin
                    if (UpdateTaken) begin
                        m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
                        m_tgt[ui] = UpdateTarget;
                    end else begin
                        m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
                    end
                end else begin
                    m_valid[ui] = 1'b1;
                    m_tag[ui]   = mtag(UpdatePC);
                    m_ctr[ui]   = UpdateTaken ? 2 : 1;
                    m_tgt[ui]   = UpdateTarget;
                end
            end
            m_pc = nxt;
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_init) begin
            chk("model_PCF", PCF, m_pc);
            chk("model_PCPlus4F", PCPlus4F, m_pc + 32'd4);
            chk("model_JumpPredictF", {31'd0, JumpPredictF}, {31'd0, m_pred(m_pc)});
            chk("model_PredTargetF", PredTargetF, m_ptgt(m_pc));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        RedirectE   = 1'b1;
        RedirectPCE = pc;
        tick();
        RedirectE   = 1'b0;
    endtask

    task automatic set_upd(input logic en, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        UpdateEn     = en;
        UpdatePC     = pc;
        UpdateTaken  = tk;
        UpdateTarget = tgt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        rst_n = 1'b0; StallF = 1'b0; RedirectE = 1'b0; RedirectPCE = '0;
        set_upd(1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("reset_PCF", PCF, 32'h0);
        chk("reset_PCPlus4F", PCPlus4F, 32'h4);
        chk("reset_JumpPredictF", {31'd0, JumpPredictF}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("step_PCF", PCF, 32'(4 * k));
        end

        StallF = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_hold_PCF", PCF, 32'h10);
        end
        StallF = 1'b0;
        tick();
        chk("stall_resume_PCF", PCF, 32'h14);

        set_upd(1'b1, 32'h20, 1'b1, 32'h100);
        tick();
        UpdateEn = 1'b0;
        tick();
        tick();
        chk("train_PCF", PCF, 32'h20);
        chk("train_JumpPredictF", {31'd0, JumpPredictF}, 32'd1);
        chk("train_PredTargetF", PredTargetF, 32'h100);
        tick();
        chk("train_follow_PCF", PCF, 32'h100);

        set_upd(1'b1, 32'h20, 1'b1, 32'h100);
        tick();
        UpdateTaken = 1'b0;
        redirect_to(32'h20);
        UpdateEn = 1'b0;
        chk("hyst_1nt_JumpPredictF", {31'd0, JumpPredictF}, 32'd1);
        UpdateEn = 1'b1;
        redirect_to(32'h20);
        UpdateEn = 1'b0;
        chk("hyst_2nt_JumpPredictF", {31'd0, JumpPredictF}, 32'd0);
        tick();
        chk("hyst_2nt_PCF", PCF, 32'h24);
        UpdateEn = 1'b1;
        tick();
        tick();
        UpdateTaken = 1'b1;
        redirect_to(32'h20);
        chk("sat_low_JumpPredictF", {31'd0, JumpPredictF}, 32'd0);
        tick();
        UpdateEn = 1'b0;
        chk("rbw_old_entry_PCF", PCF, 32'h24);
        redirect_to(32'h20);
        chk("rbw_new_entry_JumpPredictF", {31'd0, JumpPredictF}, 32'd1);
        tick();
        chk("rbw_new_entry_PCF", PCF, 32'h100);

        StallF = 1'b1;
        redirect_to(32'h400);
        chk("redirect_over_stall_PCF", PCF, 32'h400);
        tick();
        chk("stall_after_redirect_PCF", PCF, 32'h400);
        StallF = 1'b0;

        redirect_to(32'h20 + 4 * N);
        chk("alias_JumpPredictF", {31'd0, JumpPredictF}, 32'd0);
        set_upd(1'b1, 32'h20 + 4 * N, 1'b1, 32'h300);
        tick();
        UpdateEn = 1'b0;
        chk("alias_PCF", PCF, 32'h124);
        redirect_to(32'h120);
        chk("alias_trained_JumpPredictF", {31'd0, JumpPredictF}, 32'd1);
        chk("alias_trained_PredTargetF", PredTargetF, 32'h300);
        redirect_to(32'h20);
        chk("alias_evicted_JumpPredictF", {31'd0, JumpPredictF}, 32'd0);

        redirect_to(32'hFFFF_FFFC);
        chk("wrap_PCPlus4F", PCPlus4F, 32'h0);
        tick();
        chk("wrap_PCF", PCF, 32'h0);

        set_upd(1'b1, 32'h40, 1'b1, 32'h500);
        StallF = 1'b1; RedirectE = 1'b1; RedirectPCE = 32'h800; rst_n = 1'b0;
        tick();
        chk("midreset_PCF", PCF, RPC);
        rst_n = 1'b1; StallF = 1'b0; RedirectE = 1'b0; UpdateEn = 1'b0;
        redirect_to(32'h120);
        chk("midreset_cleared_JumpPredictF", {31'd0, JumpPredictF}, 32'd0);
        chk("midreset_cleared_PredTargetF", PredTargetF, 32'd0);
        redirect_to(32'h40);
        chk("midreset_no_train_JumpPredictF", {31'd0, JumpPredictF}, 32'd0);

        for (int k = 0; k < 150; k++) begin
            StallF       = ($urandom % 4) == 0;
            RedirectE    = ($urandom % 8) == 0;
            RedirectPCE  = 32'($urandom_range(0, 127)) << 2;
            UpdateEn     = ($urandom % 2) == 0;
            UpdatePC     = 32'($urandom_range(0, 127)) << 2;
            UpdateTaken  = ($urandom % 3) != 0;
            UpdateTarget = 32'($urandom_range(0, 127)) << 2;
            tick();
        end
        StallF = 1'b0; RedirectE = 1'b0; UpdateEn = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
